// File: rtl/alu_result_stage.sv
// Registered result stage after the ALU: selects a result, derives flags, queues {result, flags}.
// Latency 1 cycle into an empty buffer; 2-entry buffer gives full throughput.
// Backpressure: in_ready depends only on the registered fill count, never on res_ready.
module alu_result_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            opcode,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] a_plus_b,
  input  logic [DATA_WIDTH-1:0] a_minus_b,
  input  logic [DATA_WIDTH-1:0] not_a,
  input  logic [DATA_WIDTH-1:0] a_and_b,
  input  logic [DATA_WIDTH-1:0] a_or_b,
  input  logic [DATA_WIDTH-1:0] a_xor_b,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic [4:0]            res_flags,
  output logic [CNT_WIDTH-1:0]  err_cnt
);

  localparam int MSB = DATA_WIDTH - 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [4:0]            flags;  // {err, ovf, carry, neg, zero}
  } entry_t;

  entry_t              mem [2];
  entry_t              nxt;
  logic                wr_ptr;
  logic                rd_ptr;
  logic [1:0]          count;
  logic                push;
  logic                pop;
  logic [DATA_WIDTH:0] sum_ext;
  logic [DATA_WIDTH-1:0] res;
  logic                err;
  logic                ovf;
  logic                carry;

  assign in_ready  = (count != 2'd2);
  assign res_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = res_valid & res_ready;
  assign res_data  = mem[rd_ptr].data;
  assign res_flags = mem[rd_ptr].flags;
  assign sum_ext   = {1'b0, a} + {1'b0, b};

  always_comb begin
    res   = '0;
    err   = 1'b0;
    ovf   = 1'b0;
    carry = 1'b0;
    case (opcode)
      3'd0: begin
        res   = a_plus_b;
        carry = sum_ext[DATA_WIDTH];
        ovf   = (a[MSB] == b[MSB]) && (a_plus_b[MSB] != a[MSB]);
      end
      3'd1: begin
        res   = a_minus_b;
        carry = (a < b);
        ovf   = (a[MSB] != b[MSB]) && (a_minus_b[MSB] != a[MSB]);
      end
      3'd2:    res = not_a;
      3'd3:    res = a_and_b;
      3'd4:    res = a_or_b;
      3'd5:    res = a_xor_b;
      default: err = 1'b1;
    endcase
    nxt.data  = res;
    nxt.flags = {err, ovf, carry, res[MSB], (res == '0)};
  end

  // Writes land in the slot behind the head, so the head stays stable while stalled.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem[0]  <= '0;
      mem[1]  <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      err_cnt <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= nxt;
        wr_ptr      <= ~wr_ptr;
        if (err && (err_cnt != {CNT_WIDTH{1'b1}}))
          err_cnt <= err_cnt + 1'b1;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed + randomized bench for alu_result_stage with an in-order scoreboard of {result, flags}.
module tb_alu_result_stage;

  localparam int DW = 32;
  localparam int CW = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [4:0]    flags;
  } exp_t;

  logic          clk = 1'b0;
  logic          resetn;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    opcode;
  logic [DW-1:0] a, b;
  logic [DW-1:0] a_plus_b, a_minus_b, not_a, a_and_b, a_or_b, a_xor_b;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic [4:0]    res_flags;
  logic [CW-1:0] err_cnt;

  int   errors = 0;
  int   checks = 0;
  bit   rnd_rdy = 1'b0;
  exp_t sb[$];

  assign a_plus_b  = a + b;
  assign a_minus_b = a - b;
  assign not_a     = ~a;
  assign a_and_b   = a & b;
  assign a_or_b    = a | b;
  assign a_xor_b   = a ^ b;

  always #5 clk = ~clk;

  alu_result_stage #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .a(a), .b(b),
    .a_plus_b(a_plus_b), .a_minus_b(a_minus_b), .not_a(not_a),
    .a_and_b(a_and_b), .a_or_b(a_or_b), .a_xor_b(a_xor_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_flags(res_flags), .err_cnt(err_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference built from wide signed/unsigned arithmetic rather than sign-bit rules.
  function automatic exp_t model(input logic [2:0] op, input logic [DW-1:0] x, input logic [DW-1:0] y);
    exp_t        e;
    logic [DW:0] u;
    longint      sx, sy, sr;
    logic        c, o, er;
    logic [DW-1:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    c = 1'b0; o = 1'b0; er = 1'b0; r = '0; u = '0; sr = 0;
    case (op)
      3'd0: begin
        u = {1'b0, x} + {1'b0, y}; r = u[DW-1:0]; c = u[DW];
        sr = sx + sy; o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      3'd1: begin
        u = {1'b0, x} - {1'b0, y}; r = u[DW-1:0]; c = u[DW];
        sr = sx - sy; o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      3'd2: r = ~x;
      3'd3: r = x & y;
      3'd4: r = x | y;
      3'd5: r = x ^ y;
      default: er = 1'b1;
    endcase
    e.data  = r;
    e.flags = {er, o, c, r[DW-1], (r == 0)};
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!resetn) begin
      sb.delete();
    end else begin
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_pop", {63'd0, res_valid}, 64'd0);
        end else begin
          e = sb.pop_front();
          check("pop_data", {32'd0, res_data}, {32'd0, e.data});
          check("pop_flags", {59'd0, res_flags}, {59'd0, e.flags});
        end
      end
      if (in_valid && in_ready)
        sb.push_back(model(opcode, a, b));
    end
  end

  task automatic send(input logic [2:0] op, input logic [DW-1:0] x, input logic [DW-1:0] y);
    bit acc;
    int budget;
    acc = 1'b0;
    budget = 0;
    opcode = op; a = x; b = y; in_valid = 1'b1;
    while (!acc && budget < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (rnd_rdy) res_ready = 1'($urandom_range(0, 1));
      budget++;
    end
    if (!acc) check("send_timeout", {63'd0, acc}, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    resetn = 1'b0; in_valid = 1'b0; res_ready = 1'b1;
    opcode = 3'd0; a = '0; b = '0;
    cycles(3);
    check("rst_res_valid", {63'd0, res_valid}, 64'd0);
    check("rst_res_data", {32'd0, res_data}, 64'd0);
    check("rst_res_flags", {59'd0, res_flags}, 64'd0);
    check("rst_err_cnt", {56'd0, err_cnt}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    resetn = 1'b1;
    cycles(2);

    // Carry wraps to zero; first-transaction latency of one cycle.
    send(3'd0, 32'hFFFF_FFFF, 32'd1);
    check("add_wrap_valid", {63'd0, res_valid}, 64'd1);
    check("add_wrap_data", {32'd0, res_data}, 64'd0);
    check("add_wrap_flags", {59'd0, res_flags}, 64'b00101);
    send(3'd1, 32'h8000_0000, 32'd1);
    check("sub_ovf_data", {32'd0, res_data}, 64'h7FFF_FFFF);
    check("sub_ovf_flags", {59'd0, res_flags}, 64'b01000);
    send(3'd1, 32'd3, 32'd5);
    check("sub_borrow_data", {32'd0, res_data}, 64'hFFFF_FFFE);
    check("sub_borrow_flags", {59'd0, res_flags}, 64'b00110);
    send(3'd0, 32'h7FFF_FFFF, 32'd1);
    check("add_ovf_flags", {59'd0, res_flags}, 64'b01010);
    for (int op = 2; op < 6; op++) send(3'(op), 32'hF0F0_1234, 32'h0FF0_4321);
    cycles(2);
    check("legal_no_err_cnt", {56'd0, err_cnt}, 64'd0);
    check("drained_empty", {63'd0, res_valid}, 64'd0);

    // Back-pressure: fill both slots, third request stalls, head stays stable.
    res_ready = 1'b0;
    send(3'd0, 32'd10, 32'd20);
    send(3'd5, 32'hAAAA_0000, 32'h0000_5555);
    check("full_in_ready", {63'd0, in_ready}, 64'd0);
    opcode = 3'd3; a = 32'hFF00_FF00; b = 32'h0F0F_0F0F; in_valid = 1'b1;
    cycles(3);
    check("stall_in_ready", {63'd0, in_ready}, 64'd0);
    check("stall_head_data", {32'd0, res_data}, 64'd30);
    check("stall_head_flags", {59'd0, res_flags}, 64'd0);
    res_ready = 1'b1;
    cycles(1);
    check("ready_after_pop", {63'd0, in_ready}, 64'd1);
    cycles(1);
    in_valid = 1'b0;
    cycles(3);
    check("bp_drained", {63'd0, res_valid}, 64'd0);

    // Illegal opcodes: counter saturates.
    for (int i = 0; i < 300; i++) begin
      send(3'd6, $urandom, $urandom);
      if (i == 99) check("err_cnt_100", {56'd0, err_cnt}, 64'd100);
    end
    check("err_cnt_sat", {56'd0, err_cnt}, 64'd255);
    send(3'd7, 32'd0, 32'd0);
    check("err_cnt_sat7", {56'd0, err_cnt}, 64'd255);
    check("illegal_flags", {59'd0, res_flags}, 64'b10001);

    // Random ops with random downstream stalls.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 60; i++) send(3'($urandom_range(0, 5)), $urandom, $urandom);
    rnd_rdy = 1'b0;
    res_ready = 1'b1;
    cycles(4);
    check("rand_drained", {63'd0, res_valid}, 64'd0);

    // Reset with one entry buffered.
    res_ready = 1'b0;
    send(3'd4, 32'h1234_0000, 32'h0000_5678);
    check("pre_rst_valid", {63'd0, res_valid}, 64'd1);
    #2 resetn = 1'b0;
    #1;
    check("midrst_res_valid", {63'd0, res_valid}, 64'd0);
    check("midrst_err_cnt", {56'd0, err_cnt}, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    cycles(2);
    resetn = 1'b1;
    res_ready = 1'b1;
    cycles(3);
    check("post_rst_no_stale", {63'd0, res_valid}, 64'd0);
    send(3'd0, 32'd1, 32'd2);
    check("post_rst_add", {32'd0, res_data}, 64'd3);
    cycles(3);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
